// File: rtl/i2c_codec_cfg.sv
// i2c_codec_cfg: write-only I2C master that sends a table of 16-bit codec words as address+2-byte frames with NACK retry.
module i2c_codec_cfg #(
  parameter int         CLK_DIV   = 250,
  parameter int         NUM_WORDS = 10,
  parameter int         IDX_W     = 8,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3,
  parameter int         GAP_Q     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] cfg_index,
  input  logic [15:0]      cfg_data,
  output logic             i2c_sclk,
  output logic             i2c_sdat_oe,
  input  logic             i2c_sdat_i,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP, DONE, ERROR} state_t;
  localparam int CW = $clog2(CLK_DIV);
  localparam int QW = $clog2(GAP_Q + 4);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [QW-1:0] q;
  logic [2:0] bitc, retry;
  logic [1:0] byte_c;
  logic [23:0] sh;
  logic nack, word_ok, sclk_n, oe_n;
  logic idle, accept, tick, last_q, end_q, last_word, can_retry, q0, q1, q2, q3;
  assign idle      = state == IDLE || state == DONE || state == ERROR;
  assign accept    = idle && start;
  assign tick      = !idle && cnt == CW'(CLK_DIV - 1);
  assign q0        = q == QW'(0);
  assign q1        = q == QW'(1);
  assign q2        = q == QW'(2);
  assign q3        = q == QW'(3);
  assign last_q    = state == START ? q1 : state == STOP ? q2 : state == GAP ? q == QW'(GAP_Q - 1) : q3;
  assign end_q     = tick && last_q;
  assign last_word = cfg_index == IDX_W'(NUM_WORDS - 1);
  assign can_retry = retry < 3'(MAX_RETRY);
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i2c_sclk    <= 1'b1;
      i2c_sdat_oe <= 1'b0;
    end else begin
      state       <= state_n;
      i2c_sclk    <= sclk_n;
      i2c_sdat_oe <= oe_n;
    end
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = START;
    else if (end_q)
      case (state)
        START:   state_n = BIT;
        BIT:     state_n = bitc == 3'd7 ? ACK : BIT;
        ACK:     state_n = !nack && byte_c != 2'd2 ? BIT : STOP;
        STOP:    state_n = GAP;
        GAP:     state_n = word_ok ? (last_word ? DONE : START) : (can_retry ? START : ERROR);
        default: state_n = state;
      endcase
  end
  // Pin values for the next edge; they only move on quarter ticks.
  always_comb begin
    sclk_n = i2c_sclk;
    oe_n   = i2c_sdat_oe;
    busy   = !idle;
    done   = state == DONE;
    error  = state == ERROR;
    if (tick)
      case (state)
        START: begin
          oe_n   = q0 ? 1'b1 : i2c_sdat_oe;
          sclk_n = q1 ? 1'b0 : i2c_sclk;
        end
        BIT, ACK: begin
          sclk_n = q1 ? 1'b1 : q3 ? 1'b0 : i2c_sclk;
          oe_n   = q0 ? (state == BIT && !sh[23]) : i2c_sdat_oe;
        end
        STOP: begin
          sclk_n = q1 ? 1'b1 : i2c_sclk;
          oe_n   = q0 ? 1'b1 : q2 ? 1'b0 : i2c_sdat_oe;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      q         <= '0;
      cfg_index <= '0;
      err_index <= '0;
      retry     <= '0;
      sh        <= '0;
      bitc      <= '0;
      byte_c    <= '0;
      nack      <= 1'b0;
      word_ok   <= 1'b0;
    end else if (accept) begin
      cnt       <= '0;
      q         <= '0;
      cfg_index <= '0;
      retry     <= '0;
    end else if (!idle) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) q <= last_q ? '0 : q + 1'b1;
      if (tick && state == START && q1) begin
        sh     <= {DEV_ADDR, 1'b0, cfg_data};
        bitc   <= '0;
        byte_c <= '0;
      end
      if (tick && state == BIT && q3) begin
        sh   <= {sh[22:0], 1'b0};
        bitc <= bitc + 1'b1;
      end
      if (tick && state == ACK && q2) nack <= i2c_sdat_i;
      if (tick && state == ACK && q3) begin
        byte_c  <= byte_c + 1'b1;
        word_ok <= !nack;
      end
      if (end_q && state == GAP) begin
        if (word_ok) begin
          if (!last_word) cfg_index <= cfg_index + 1'b1;
          retry <= '0;
        end else if (can_retry) retry <= retry + 1'b1;
        else err_index <= cfg_index;
      end
    end
  end
endmodule
